// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch front end. A three-state FSM keeps at most one I-cache
//   request in flight. Each response is pushed into a DEPTH-entry queue along
//   with its PC, PC+4 and the branch prediction. Decode pops entries from the
//   head of that queue. A redirect from execute empties the queue and restarts
//   fetch at a new PC. If a request is still in flight when the redirect
//   arrives, its response is thrown away (DROP state).
//
//   Optional feature: IF_FETCH_PERF_CNT_EN adds three saturating 32-bit
//   performance counters (fetches, full-queue stall cycles, redirect cycles).
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   redirect_i/_pc_i         flush queue and restart fetch at redirect_pc_i
//   icache_req_o/_addr_o     fetch request and address (also the predictor PC)
//   icache_gnt_i             cache accepted the request
//   icache_valid_i/_data_i   response and instruction
//   bp_taken_i/bp_target_i   prediction for the responding address
//   deq_valid_o/deq_ready_i  queue head handshake with decode
//   deq_pc_o/_pc4_o/_inst_o  head PC, PC+4 and instruction
//   deq_bp_taken_o           head prediction bit
//   perf_*_o                 performance counters (IF_FETCH_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module if_fetch_queue #(
   parameter int XLEN = 32,
   parameter int DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            icache_req_o,
   output logic [XLEN-1:0] icache_addr_o,
   input  logic            icache_gnt_i,
   input  logic            icache_valid_i,
   input  logic [XLEN-1:0] icache_data_i,
   input  logic            bp_taken_i,
   input  logic [XLEN-1:0] bp_target_i,
   output logic            deq_valid_o,
   input  logic            deq_ready_i,
   output logic [XLEN-1:0] deq_pc_o,
   output logic [XLEN-1:0] deq_pc4_o,
   output logic [XLEN-1:0] deq_inst_o,
   output logic            deq_bp_taken_o
`ifdef IF_FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetch_o,
   output logic [31:0]     perf_stall_o,
   output logic [31:0]     perf_flush_o
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;

   state_t          state;
   logic [XLEN-1:0] fetch_pc;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;

   logic [XLEN-1:0] q_pc   [DEPTH];
   logic [XLEN-1:0] q_pc4  [DEPTH];
   logic [XLEN-1:0] q_inst [DEPTH];
   logic            q_bp   [DEPTH];

   logic not_full, push, pop;

   // The single-outstanding rule makes the count check at issue enough to
   // reserve the slot. Pops can only free slots while the request is in flight.
   assign not_full      = (count < CW'(DEPTH));
   assign icache_req_o  = !rst_i && (state == RUN) && not_full && !redirect_i;
   assign icache_addr_o = fetch_pc;

   // A redirect overrides push and pop for the whole cycle.
   assign push = (state == WAIT) && icache_valid_i && !redirect_i;
   assign pop  = deq_valid_o && deq_ready_i && !redirect_i;

   assign deq_valid_o    = (count != '0);
   assign deq_pc_o       = q_pc[rd_ptr];
   assign deq_pc4_o      = q_pc4[rd_ptr];
   assign deq_inst_o     = q_inst[rd_ptr];
   assign deq_bp_taken_o = q_bp[rd_ptr];

   // Fetch FSM and fetch PC.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
      end else if (redirect_i) begin
         fetch_pc <= redirect_pc_i;
         // A response that arrives in the redirect cycle is the one being
         // abandoned. After it, nothing is in flight, so go back to RUN.
         // Otherwise wait in DROP for the response still on its way.
         if (state != RUN)
            state <= icache_valid_i ? RUN : DROP;
      end else begin
         case (state)
            RUN:  if (icache_req_o && icache_gnt_i) state <= WAIT;
            WAIT: if (icache_valid_i) begin
                     state    <= RUN;
                     fetch_pc <= bp_taken_i ? bp_target_i : fetch_pc + XLEN'(4);
                  end
            DROP: if (icache_valid_i) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // Queue storage and occupancy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i]   <= '0;
            q_pc4[i]  <= '0;
            q_inst[i] <= '0;
            q_bp[i]   <= 1'b0;
         end
      end else if (redirect_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            q_pc[wr_ptr]   <= fetch_pc;
            q_pc4[wr_ptr]  <= fetch_pc + XLEN'(4);
            q_inst[wr_ptr] <= icache_data_i;
            q_bp[wr_ptr]   <= bp_taken_i;
            wr_ptr         <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

`ifdef IF_FETCH_PERF_CNT_EN
   // All three counters saturate instead of wrapping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_fetch_o <= '0;
         perf_stall_o <= '0;
         perf_flush_o <= '0;
      end else begin
         if (push && perf_fetch_o != 32'hFFFF_FFFF)
            perf_fetch_o <= perf_fetch_o + 32'd1;
         if (state == RUN && !not_full && perf_stall_o != 32'hFFFF_FFFF)
            perf_stall_o <= perf_stall_o + 32'd1;
         if (redirect_i && perf_flush_o != 32'hFFFF_FFFF)
            perf_flush_o <= perf_flush_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_queue
//   Directed bench for if_fetch_queue in its default build. Inputs change just
//   after the rising edge or on the falling edge. Outputs are sampled on the
//   falling edge. Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        icache_req;
   logic [31:0] icache_addr;
   logic        icache_gnt = 1'b1;
   logic        icache_valid = 1'b0;
   logic [31:0] icache_data = '0;
   logic        bp_taken = 1'b0;
   logic [31:0] bp_target = '0;
   logic        deq_valid;
   logic        deq_ready = 1'b1;
   logic [31:0] deq_pc, deq_pc4, deq_inst;
   logic        deq_bp_taken;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk_i(clk), .rst_i(rst),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .icache_req_o(icache_req), .icache_addr_o(icache_addr),
      .icache_gnt_i(icache_gnt), .icache_valid_i(icache_valid),
      .icache_data_i(icache_data),
      .bp_taken_i(bp_taken), .bp_target_i(bp_target),
      .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
      .deq_pc_o(deq_pc), .deq_pc4_o(deq_pc4), .deq_inst_o(deq_inst),
      .deq_bp_taken_o(deq_bp_taken)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Entered and left on a falling edge in RUN. One complete fetch:
   // request/grant, then the response one cycle later. On return the entry
   // sits at the queue head if the queue was empty.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                        input logic bp, input logic [31:0] tgt);
      chk("req", {31'b0, icache_req}, 32'd1);
      chk("addr", icache_addr, addr);
      @(posedge clk); #1;
      icache_valid = 1'b1; icache_data = data; bp_taken = bp; bp_target = tgt;
      @(negedge clk);
      chk("req_wait", {31'b0, icache_req}, 32'd0);
      @(posedge clk); #1;
      icache_valid = 1'b0; bp_taken = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_req", {31'b0, icache_req}, 32'd0);
      chk("rst_dv", {31'b0, deq_valid}, 32'd0);
      chk("rst_pc", deq_pc, 32'd0);
      chk("rst_pc4", deq_pc4, 32'd0);
      chk("rst_inst", deq_inst, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);

      // Sequential stream with decode always ready
      fetch(32'h0, 32'h0000_0013, 1'b0, '0);
      chk("dv0", {31'b0, deq_valid}, 32'd1);
      chk("dpc0", deq_pc, 32'h0);
      chk("dpc4_0", deq_pc4, 32'h4);
      chk("dinst0", deq_inst, 32'h0000_0013);
      fetch(32'h4, 32'h0000_0093, 1'b0, '0);
      chk("dpc1", deq_pc, 32'h4);
      chk("dpc4_1", deq_pc4, 32'h8);
      chk("dbp1", {31'b0, deq_bp_taken}, 32'd0);
      // Predicted-taken entry at 0x8
      fetch(32'h8, 32'h0400_006F, 1'b1, 32'h40);
      chk("dpc2", deq_pc, 32'h8);
      chk("dbp2", {31'b0, deq_bp_taken}, 32'd1);
      fetch(32'h40, 32'h1, 1'b0, '0);   // the predicted target is fetched next

      // Decode stalled: queue fills to 4 and requests stop
      deq_ready = 1'b0;
      fetch(32'h44, 32'h2, 1'b0, '0);
      fetch(32'h48, 32'h3, 1'b0, '0);
      fetch(32'h4C, 32'h4, 1'b0, '0);
      chk("full_req", {31'b0, icache_req}, 32'd0);
      chk("full_hold", deq_pc, 32'h40);
      @(negedge clk);
      chk("full_req2", {31'b0, icache_req}, 32'd0);
      chk("full_inst", deq_inst, 32'h1);
      deq_ready = 1'b1;
      @(posedge clk); #1 deq_ready = 1'b0;
      @(negedge clk);
      chk("refill_req", {31'b0, icache_req}, 32'd1);
      chk("refill_addr", icache_addr, 32'h50);
      chk("refill_head", deq_pc, 32'h44);

      // Redirect in WAIT; the response arrives two cycles later and is dropped
      @(posedge clk); #1;
      redirect = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      chk("redir_req", {31'b0, icache_req}, 32'd0);
      @(posedge clk); #1 redirect = 1'b0;
      @(negedge clk);
      chk("drop_dv", {31'b0, deq_valid}, 32'd0);
      chk("drop_req", {31'b0, icache_req}, 32'd0);
      @(posedge clk); #1 icache_valid = 1'b1; icache_data = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("drop_req2", {31'b0, icache_req}, 32'd0);
      @(posedge clk); #1 icache_valid = 1'b0;
      @(negedge clk);
      chk("drop_dv2", {31'b0, deq_valid}, 32'd0);
      chk("drop_req3", {31'b0, icache_req}, 32'd1);
      chk("drop_addr", icache_addr, 32'h100);

      // Redirect coinciding with a response and a pop
      fetch(32'h100, 32'h5, 1'b0, '0);
      chk("co_head", deq_pc, 32'h100);
      @(posedge clk); #1;                 // 0x104 granted, now in WAIT
      icache_valid = 1'b1; icache_data = 32'h6;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; deq_ready = 1'b1;
      @(negedge clk);
      chk("co_req", {31'b0, icache_req}, 32'd0);
      @(posedge clk); #1;
      icache_valid = 1'b0; redirect = 1'b0;
      @(negedge clk);
      chk("co_dv", {31'b0, deq_valid}, 32'd0);
      chk("co_req2", {31'b0, icache_req}, 32'd1);
      // PC+4 wraps past the top of the address space
      fetch(32'hFFFF_FFFC, 32'h7, 1'b0, '0);
      chk("wrap_pc", deq_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", deq_pc4, 32'h0);
      chk("wrap_next", icache_addr, 32'h0);

      // Reset while WAIT: the late response must not be queued
      @(posedge clk); #1 rst = 1'b1;
      #1;
      chk("mrst_req", {31'b0, icache_req}, 32'd0);
      chk("mrst_dv", {31'b0, deq_valid}, 32'd0);
      chk("mrst_pc", deq_pc, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; icache_valid = 1'b1; icache_data = 32'hBAD;
      @(negedge clk);
      chk("mrst_req2", {31'b0, icache_req}, 32'd1);
      chk("mrst_addr", icache_addr, 32'h0);
      @(posedge clk); #1 icache_valid = 1'b0;
      @(negedge clk);
      chk("mrst_dv2", {31'b0, deq_valid}, 32'd0);
      @(posedge clk); #1 icache_valid = 1'b1; icache_data = 32'h600D;
      @(posedge clk); #1 icache_valid = 1'b0;
      @(negedge clk);
      chk("mrst_dv3", {31'b0, deq_valid}, 32'd1);
      chk("mrst_inst", deq_inst, 32'h600D);
      chk("mrst_dpc", deq_pc, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
